mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data-memory handshake, lane steering, MEM/WB register.
// Optional feature: MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
module mem_access_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic [3:0]  ex_rd,
  input  logic        ex_rf_en,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [1:0]  ex_size,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic [3:0]  wb_rd,
  output logic        wb_rf_en,
  output logic [31:0] mem_fwd_data,
  output logic        bus_error,
  output logic        align_fault
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [0:0]  state;
  logic [7:0]  wait_cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic [3:0]  lat_rd;
  logic [1:0]  lat_size;
  logic        lat_load;
  logic        lat_store;

  logic        mem_op;
  logic        misaligned;
  logic        start;
  logic        in_access;
  logic        timeout;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;

  assign mem_op    = ex_valid & (ex_load | ex_store);
  assign in_access = (state == ACCESS);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((ex_size == 2'b01) & ex_addr[0]) | (ex_size[1] & (ex_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign start = (state == IDLE) & mem_op & ~misaligned;

  // The abort cycle releases stall so the dead instruction leaves EXE/MEM instead of being reissued.
  assign timeout = in_access & ~dm_ack & (wait_cnt == WAIT_LAST);
  assign stall   = ~reset & (start | (in_access & ~dm_ack & ~timeout));

  assign mem_fwd_data = ex_addr;

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = lat_data;
    case (lat_size)
      2'b00: begin
        lane_be    = 4'b0001 << lat_addr[1:0];
        lane_wdata = {4{lat_data[7:0]}};
      end
      2'b01: begin
        lane_be    = lat_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{lat_data[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = lat_data;
      end
    endcase
  end

  always_comb begin
    load_data = dm_rdata;
    case (lat_size)
      2'b00: begin
        case (lat_addr[1:0])
          2'b00:   load_data = {24'h0, dm_rdata[7:0]};
          2'b01:   load_data = {24'h0, dm_rdata[15:8]};
          2'b10:   load_data = {24'h0, dm_rdata[23:16]};
          default: load_data = {24'h0, dm_rdata[31:24]};
        endcase
      end
      2'b01:   load_data = lat_addr[1] ? {16'h0, dm_rdata[31:16]} : {16'h0, dm_rdata[15:0]};
      default: load_data = dm_rdata;
    endcase
  end

  // Bus outputs come only from the latched request so they stay stable while EXE/MEM is frozen.
  assign dm_req   = in_access;
  assign dm_we    = in_access & lat_store;
  assign dm_addr  = in_access ? {lat_addr[31:2], 2'b00} : 32'h0;
  assign dm_be    = in_access ? lane_be : 4'h0;
  assign dm_wdata = in_access ? lane_wdata : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 8'h0;
      lat_addr  <= 32'h0;
      lat_data  <= 32'h0;
      lat_rd    <= 4'h0;
      lat_size  <= 2'b00;
      lat_load  <= 1'b0;
      lat_store <= 1'b0;
      wb_data   <= 32'h0;
      wb_rd     <= 4'h0;
      wb_rf_en  <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      bus_error <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state     <= ACCESS;
          wait_cnt  <= 8'h0;
          lat_addr  <= ex_addr;
          lat_data  <= ex_store_data;
          lat_rd    <= ex_rd;
          lat_size  <= ex_size;
          lat_load  <= ex_load & ~ex_store;
          lat_store <= ex_store;
          wb_rf_en  <= 1'b0;
        end else if (ex_valid & ~ex_load & ~ex_store) begin
          wb_data  <= ex_addr;
          wb_rd    <= ex_rd;
          wb_rf_en <= ex_rf_en;
        end else begin
          wb_rf_en <= 1'b0;
        end
      end else begin
        if (dm_ack) begin
          state    <= IDLE;
          wb_rd    <= lat_rd;
          wb_rf_en <= lat_load;
          if (lat_load) begin
            wb_data <= load_data;
          end
        end else if (timeout) begin
          state     <= IDLE;
          bus_error <= 1'b1;
          wb_rf_en  <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt + 8'h1;
          wb_rf_en <= 1'b0;
        end
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      align_fault <= 1'b0;
    end else begin
      align_fault <= (state == IDLE) & mem_op & misaligned;
    end
  end
`else
  assign align_fault = 1'b0;
`endif

endmodule
